// File: rtl/result_to_digits.sv
// result_to_digits: converts a signed 16-bit result to BCD via double-dabble and
// streams the digits most significant first with leading zeros suppressed.
module result_to_digits (
    input  logic        clk,
    input  logic        RST,
    input  logic        start,
    input  logic [15:0] value,
    output logic        busy,
    output logic        negative,
    output logic [3:0]  digit_out,
    output logic        digit_valid,
    input  logic        digit_ready,
    output logic        digit_last
);
    typedef enum logic [1:0] {IDLE, CONVERT, EMIT} state_t;

    state_t      state_q;
    logic        negative_q;
    logic [15:0] mag_q, mag_d;
    logic [19:0] bcd_q, bcd_d, adj;
    logic [19:0] shifted;
    logic [3:0]  cnt_q;
    logic [2:0]  ptr_q, lead;

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < 5; i++)
            if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        bcd_d = {adj[18:0], mag_q[15]};
        mag_d = {mag_q[14:0], 1'b0};
        // Pointer for EMIT comes from the post-iteration value so it is ready on entry.
        lead = 3'd0;
        for (int i = 0; i < 5; i++)
            if (bcd_d[4*i +: 4] != 4'd0) lead = 3'(i);
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q    <= IDLE;
            negative_q <= 1'b0;
            mag_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ptr_q      <= '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    negative_q <= value[15];
                    mag_q      <= value[15] ? (~value + 16'd1) : value;
                    bcd_q      <= '0;
                    cnt_q      <= '0;
                    state_q    <= CONVERT;
                end
                CONVERT: begin
                    bcd_q <= bcd_d;
                    mag_q <= mag_d;
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        ptr_q   <= lead;
                        state_q <= EMIT;
                    end
                end
                EMIT: if (digit_ready) begin
                    if (ptr_q == 3'd0) state_q <= IDLE;
                    else ptr_q <= ptr_q - 3'd1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign shifted     = bcd_q >> {ptr_q, 2'b00};
    assign busy        = state_q != IDLE;
    assign negative    = negative_q;
    assign digit_valid = state_q == EMIT;
    assign digit_out   = digit_valid ? shifted[3:0] : 4'd0;
    assign digit_last  = digit_valid && ptr_q == 3'd0;
endmodule

// File: doc/result_to_digits.md
RESULT_TO_DIGITS -- requirements
Module: result_to_digits

Interface
REQ-001 SHALL have no parameters; the data width is fixed at 16 bits and the digit count at 5.
REQ-002 SHALL provide port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL provide port: RST  input  1  reset, synchronous and active-high.
REQ-004 SHALL provide port: start  input  1  request to convert value; sampled only in IDLE.
REQ-005 SHALL provide port: value  input  16  signed two's-complement calculator result; captured when start is accepted.
REQ-006 SHALL provide port: busy  output  1  high in every state except IDLE.
REQ-007 SHALL provide port: negative  output  1  sign of the last captured value; held until the next accepted start.
REQ-008 SHALL provide port: digit_out  output  4  BCD digit, 0..9.
REQ-009 SHALL provide port: digit_valid  output  1  digit_out is valid.
REQ-010 SHALL provide port: digit_ready  input  1  consumer accepts digit_out.
REQ-011 SHALL provide port: digit_last  output  1  high with the ones digit.

Function
REQ-012 SHALL implement the states IDLE, CONVERT and EMIT.
REQ-013 In IDLE with start=1 at an edge, SHALL perform all of the following:
- capture the sign into negative;
- load magnitude = value[15] ? (~value + 1) : value, as 16-bit unsigned, so that 0x8000 gives 32768;
- clear the 20-bit BCD register;
- go to CONVERT.
REQ-014 CONVERT SHALL perform exactly one double-dabble iteration per cycle for 16 cycles: add 3 to each BCD nibble that is >=5, then shift {bcd, magnitude} left by one.
REQ-015 After the 16th iteration edge, SHALL enter EMIT, so that digit_valid first rises 16 cycles after the start-accepting edge.
REQ-016 On entering EMIT, SHALL point the digit pointer at the most significant nonzero BCD nibble, or at the ones nibble if all nibbles are zero.
REQ-017 SHALL present digits from most to least significant, suppressing leading zeros only; interior and trailing zeros SHALL be emitted.
REQ-018 SHALL hold digit_out and digit_last stable while digit_valid=1 and digit_ready=0.
REQ-019 A transfer SHALL occur at an edge where digit_valid=1 and digit_ready=1; the pointer then advances one nibble toward the ones digit.
REQ-020 SHALL return to IDLE on the transfer that carries digit_last=1; digit_valid SHALL be 0 in the following cycle.
REQ-021 SHALL ignore start outside IDLE, with no effect on the in-flight conversion or on negative.
REQ-022 SHALL accept a start in the first IDLE cycle after the final transfer, with no dead cycle.
REQ-023 digit_valid SHALL be 0 in IDLE and CONVERT; digit_ready SHALL be ignored outside EMIT.
REQ-024 SHALL drive digit_out and digit_last to 0 whenever digit_valid=0.
REQ-025 SHALL have no combinational path from digit_ready to digit_valid or digit_out.

Reset
REQ-026 RST=1 at an edge SHALL force IDLE, busy=0, negative=0, digit_valid=0, digit_out=0 and digit_last=0, and clear the magnitude and BCD registers.
REQ-027 RST SHALL take priority over start and over any handshake in the same cycle.
REQ-028 RST asserted mid-CONVERT or mid-EMIT SHALL abandon the operation; no remaining digits are emitted.

Verification
REQ-029 value=12345 (0x3039), start pulse, digit_ready=1:
- negative=0;
- digits 1,2,3,4,5 on consecutive cycles, digit_last only on 5;
- first digit_valid 16 cycles after the start edge;
- busy=0 the cycle after the transfer of 5.
REQ-030 value=0x8000: negative=1, digits 3,2,7,6,8.
REQ-031 value=0: a single digit 0 with digit_last=1, negative=0.
REQ-032 value=0xFFF9 (-7), digit_ready held low 5 cycles then high:
- negative=1;
- digit 7 held stable with digit_valid=1 throughout the stall;
- single transfer with digit_last=1.
REQ-033 value=1000 started; start re-pulsed with value=5 while busy:
- second start ignored;
- output is 1,0,0,0 with digit_last on the final 0.
REQ-034 value=12345 started; RST pulsed after two transfers:
- next cycle digit_valid=0, busy=0, negative=0;
- a subsequent start with value=42 yields 4,2.
